// File: rtl/line_buffer_pe_arbiter_pkg.sv
// Shared definitions for the line-buffer side of a conv layer: FSM states and pixel width.
package line_buffer_pe_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    function automatic int pixel_w(input int data_width, input int in_channel);
        return data_width * in_channel;
    endfunction

endpackage

// File: rtl/line_buffer_pe_arbiter_rr_priority_encoder.sv
// Round-robin priority encoder: first set request strictly after 'last', wrapping at N.
module rr_priority_encoder #(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic        found;
    int unsigned pos;

    always_comb begin
        any   = |req;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        // Offsets 1..N visit every index once; offset N lands back on 'last' itself.
        for (int unsigned k = 1; k <= N; k++) begin
            pos = (int'(last) + k) % N;
            if (!found && req[pos]) begin
                idx   = pos[IDX_W-1:0];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/line_buffer_pe_arbiter.sv
// Shares one convolution PE between NUM_REQ line buffers with round-robin grants,
// a registered window path to the PE and per-window ack routing back to the winner.
module line_buffer_pe_arbiter
    import line_buffer_pe_arbiter_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int IN_CHANNEL = 16,
    parameter  int KERNEL_PTS = 9,
    parameter  int NUM_REQ    = 4,
    localparam int IDX_W      = $clog2(NUM_REQ),
    localparam int PIXEL_W    = pixel_w(DATA_WIDTH, IN_CHANNEL),
    localparam int WIN_W      = KERNEL_PTS * PIXEL_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ*WIN_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic [WIN_W-1:0]           pe_data,
    output logic                       pe_valid,
    input  logic                       pe_ready,
    input  logic                       pe_ack,
    output logic [IDX_W-1:0]           grant_idx,
    output logic                       proto_err
);

    arb_state_t         state;
    logic               rr_any;
    logic [IDX_W-1:0]   rr_idx;
    logic [NUM_REQ-1:0] one;

    assign one = {{(NUM_REQ-1){1'b0}}, 1'b1};

    rr_priority_encoder #(.N(NUM_REQ)) u_rr (
        .req  (req_valid),
        .last (grant_idx),
        .any  (rr_any),
        .idx  (rr_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            pe_valid  <= 1'b0;
            pe_data   <= '0;
            req_ready <= '0;
            grant_idx <= IDX_W'(NUM_REQ - 1);
            proto_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pe_ack)
                        proto_err <= 1'b1;
                    if (rr_any && pe_ready) begin
                        state     <= ST_GRANT;
                        grant_idx <= rr_idx;
                        pe_data   <= req_data[int'(rr_idx)*WIN_W +: WIN_W];
                        pe_valid  <= 1'b1;
                        req_ready <= one << rr_idx;
                    end
                end
                ST_GRANT: begin
                    // A requester dropping valid early is flagged, but the captured window is still delivered.
                    if (!req_valid[grant_idx])
                        proto_err <= 1'b1;
                    if (pe_ack) begin
                        state     <= ST_IDLE;
                        pe_valid  <= 1'b0;
                        req_ready <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        req_ack = '0;
        if (state == ST_GRANT && pe_ack)
            req_ack[grant_idx] = 1'b1;
    end

endmodule

// File: tb/tb_line_buffer_pe_arbiter.sv
// Directed and randomised checks of line_buffer_pe_arbiter with a small pixel width.
module tb_line_buffer_pe_arbiter;

    localparam int DW    = 8;
    localparam int IC    = 2;
    localparam int KP    = 9;
    localparam int NR    = 4;
    localparam int IDX_W = 2;
    localparam int W     = KP * DW * IC;

    logic                clk = 1'b0;
    logic                rst;
    logic [NR*W-1:0]     req_data;
    logic [NR-1:0]       req_valid, req_ready, req_ack;
    logic [W-1:0]        pe_data;
    logic                pe_valid, pe_ready, pe_ack, proto_err;
    logic [IDX_W-1:0]    grant_idx;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] win [NR];

    always #5 clk = ~clk;

    line_buffer_pe_arbiter #(
        .DATA_WIDTH (DW),
        .IN_CHANNEL (IC),
        .KERNEL_PTS (KP),
        .NUM_REQ    (NR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_data  (req_data),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_ack   (req_ack),
        .pe_data   (pe_data),
        .pe_valid  (pe_valid),
        .pe_ready  (pe_ready),
        .pe_ack    (pe_ack),
        .grant_idx (grant_idx),
        .proto_err (proto_err)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mkwin(input int i, input int seed);
        logic [W-1:0] w;
        w = '0;
        for (int b = 0; b < W/8; b++)
            w[b*8 +: 8] = 8'(seed*37 + i*11 + b*3 + 1);
        return w;
    endfunction

    function automatic logic [NR-1:0] onehot(input int i);
        logic [NR-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int rr(input int last, input logic [NR-1:0] v);
        for (int k = 1; k <= NR; k++)
            if (v[(last + k) % NR]) return (last + k) % NR;
        return 0;
    endfunction

    task automatic set_win(input int i, input logic [W-1:0] w);
        win[i] = w;
        req_data[i*W +: W] = w;
    endtask

    task automatic set_windows(input int seed);
        for (int i = 0; i < NR; i++) set_win(i, mkwin(i, seed));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max, output int n);
        n = 0;
        while (!pe_valid && n < max) begin
            tick();
            n++;
        end
        if (!pe_valid) check("wait_valid_timeout", W'(pe_valid), W'(1));
    endtask

    // Checks the in-flight grant, acks it after 'delay' cycles, then checks return to idle.
    task automatic serve(input string tag, input int exp_idx, input int delay);
        check({tag, "_idx"}, W'(grant_idx), W'(exp_idx));
        check({tag, "_ready"}, W'(req_ready), W'(onehot(exp_idx)));
        check({tag, "_data"}, pe_data, win[exp_idx]);
        repeat (delay) begin
            tick();
            check({tag, "_noack"}, W'(req_ack), W'(0));
        end
        pe_ack = 1'b1;
        #1;
        check({tag, "_ack"}, W'(req_ack), W'(onehot(exp_idx)));
        tick();
        pe_ack = 1'b0;
        check({tag, "_idle"}, W'(pe_valid), W'(0));
    endtask

    initial begin
        int n, g, last, delay, windows, cycles;
        int waits [NR];
        logic prev_pv, prev_rdy, prev_ack;
        logic [NR-1:0] prev_rv;

        rst = 1'b1; pe_ack = 1'b0; pe_ready = 1'b0; req_valid = '0; req_data = '0;
        set_windows(1);
        tick(); tick();
        check("rst_pe_valid", W'(pe_valid), W'(0));
        check("rst_pe_data", pe_data, W'(0));
        check("rst_req_ready", W'(req_ready), W'(0));
        check("rst_req_ack", W'(req_ack), W'(0));
        check("rst_grant_idx", W'(grant_idx), W'(3));
        check("rst_proto_err", W'(proto_err), W'(0));

        // all four requesting: strict rotation 0,1,2,3,0
        rst = 1'b0; req_valid = 4'b1111; pe_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_valid(5, n);
            check("t1_latency", W'(n), W'(1));
            serve("t1", k % NR, 2);
        end

        // single requester 2 repeatedly, new data each window
        req_valid = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            set_windows(k + 2);
            wait_valid(5, n);
            check("t2_gap", W'(n), W'(1));
            serve("t2", 2, 1);
        end

        // pe_ready low blocks arbitration; last grant 2 so requester 0 wins next
        req_valid = 4'b0101; pe_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("t3_stall", W'(pe_valid), W'(0));
        end
        pe_ready = 1'b1;
        tick();
        check("t3_grant", W'(pe_valid), W'(1));
        serve("t3", 0, 0);

        // stray pe_ack in idle
        req_valid = '0;
        pe_ack = 1'b1;
        #1;
        check("t4_stray_ack", W'(req_ack), W'(0));
        tick();
        pe_ack = 1'b0;
        check("t4_proto_err", W'(proto_err), W'(1));
        check("t4_still_idle", W'(pe_valid), W'(0));
        tick(); tick(); tick();
        check("t4_proto_sticky", W'(proto_err), W'(1));
        // requester 1 withdraws mid-grant; window still delivered
        req_valid = 4'b0010;
        wait_valid(5, n);
        check("t4_grant1", W'(grant_idx), W'(1));
        req_valid = '0;
        tick(); tick();
        check("t4_held", W'(pe_valid), W'(1));
        serve("t4", 1, 0);

        // reset in the middle of a grant
        req_valid = 4'b0100;
        wait_valid(5, n);
        check("t5_grant2", W'(grant_idx), W'(2));
        tick();
        rst = 1'b1; pe_ack = 1'b1;
        #1;
        check("t5_pe_valid", W'(pe_valid), W'(0));
        check("t5_req_ready", W'(req_ready), W'(0));
        check("t5_grant_idx", W'(grant_idx), W'(3));
        check("t5_no_ack", W'(req_ack), W'(0));
        check("t5_proto_clr", W'(proto_err), W'(0));
        pe_ack = 1'b0;
        tick();
        rst = 1'b0; req_valid = 4'b1111;
        wait_valid(5, n);
        serve("t5", 0, 1);

        // randomised traffic against a round-robin reference
        req_valid = '0; pe_ready = 1'b0;
        prev_pv = 1'b0; prev_rv = '0; prev_rdy = 1'b0; prev_ack = 1'b0;
        last = 0; delay = 0; windows = 0; cycles = 0;
        for (int i = 0; i < NR; i++) waits[i] = 0;
        while (windows < 10000 && cycles < 90000) begin
            tick();
            cycles++;
            if (!prev_pv) begin
                if (prev_rv != '0 && prev_rdy) begin
                    g = rr(last, prev_rv);
                    check("rnd_grant", W'(pe_valid), W'(1));
                    check("rnd_idx", W'(grant_idx), W'(g));
                    check("rnd_data", pe_data, win[g]);
                    for (int i = 0; i < NR; i++)
                        if (i != g && prev_rv[i]) begin
                            waits[i]++;
                            check("rnd_wait", W'(waits[i] <= NR - 1), W'(1));
                        end
                    waits[g] = 0;
                    last = g;
                    windows++;
                    delay = $urandom_range(0, 2);
                end else begin
                    check("rnd_idle", W'(pe_valid), W'(0));
                end
            end else begin
                check("rnd_hold", W'(pe_valid), W'(!prev_ack));
            end
            check("rnd_ready", W'(req_ready), W'(pe_valid ? onehot(last) : '0));

            if (prev_ack) req_valid[last] = 1'b0;
            pe_ack = 1'b0;
            if (pe_valid) begin
                if (delay == 0) pe_ack = 1'b1;
                else delay--;
            end
            for (int i = 0; i < NR; i++)
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    set_win(i, W'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()}));
                    req_valid[i] = 1'b1;
                end
            pe_ready = ($urandom_range(0, 3) != 0);
            prev_pv = pe_valid; prev_rv = req_valid; prev_rdy = pe_ready; prev_ack = pe_ack;
            #1;
            check("rnd_ack", W'(req_ack), W'(pe_ack ? onehot(last) : '0));
        end
        pe_ack = 1'b0;
        check("rnd_windows", W'(windows), W'(10000));
        check("rnd_proto_err", W'(proto_err), W'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
